// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: registers ALU operands, waits ALU_LATENCY cycles, returns the captured result on a valid/ready channel
module alu_cmd_issuer #(
  parameter int WIDTH       = 16,
  parameter int ALU_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_use_acc,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic             rsp_illegal,
  output logic [WIDTH-1:0] acc,
  output logic [15:0]      op_count
);
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_q, res_d, acc_q, acc_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             ovf_q, ovf_d, zero_q, zero_d, ill_q, ill_d;
  logic [15:0]      op_count_q, op_count_d;
  logic             accept, capture, rsp_hs, op_ill;
  assign accept  = state_q == S_IDLE && req_valid;
  assign capture = state_q == S_WAIT && cnt_q == 4'd1;
  assign rsp_hs  = state_q == S_RESP && rsp_ready;
  assign op_ill  = &alu_op_q[2:1];
  // operand A samples acc before any same-edge clear; clear wins over capture
  always_comb begin
    state_d    = accept ? S_WAIT : capture ? S_RESP : rsp_hs ? S_IDLE : state_q;
    cnt_d      = accept ? 4'(ALU_LATENCY) : state_q == S_WAIT ? cnt_q - 4'd1 : cnt_q;
    alu_a_d    = accept ? (req_use_acc ? acc_q : req_a) : alu_a_q;
    alu_b_d    = accept ? req_b : alu_b_q;
    alu_op_d   = accept ? req_op : alu_op_q;
    res_d      = capture ? alu_result : res_q;
    ovf_d      = capture ? alu_overflow : ovf_q;
    zero_d     = capture ? alu_result == '0 : zero_q;
    ill_d      = capture ? op_ill : ill_q;
    acc_d      = acc_clr ? '0 : (capture && !op_ill) ? alu_result : acc_q;
    op_count_d = rsp_hs ? op_count_q + 16'd1 : op_count_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
      ill_q      <= 1'b0;
      acc_q      <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
      ill_q      <= ill_d;
      acc_q      <= acc_d;
      op_count_q <= op_count_d;
    end
  end
  assign req_ready    = state_q == S_IDLE;
  assign rsp_valid    = state_q == S_RESP;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign rsp_result   = res_q;
  assign rsp_overflow = ovf_q;
  assign rsp_zero     = zero_q;
  assign rsp_illegal  = ill_q;
  assign acc          = acc_q;
  assign op_count     = op_count_q;
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator side of the ALU operand/opcode interface.
- Accepts operation commands on a valid/ready request channel and drives registered inputA/inputB/opcode into the ALU.
- Waits a fixed number of cycles for the ALU result, then captures result and overflow_flag and returns them on a valid/ready response channel.
- Keeps a result accumulator so commands can chain on the previous result; sits between the control sequencer and the structural ALU.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU.
- ALU_LATENCY, 1, cycles from the operand-register update to the result-sample edge; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  command present.
- req_ready  output  1  issuer can accept a command.
- req_op  input  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT; 110 and 111 are illegal.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- req_use_acc  input  1  when 1, operand A is taken from the accumulator instead of req_a.
- acc_clr  input  1  synchronous accumulator clear.
- alu_a  output  WIDTH  registered, drives ALU inputA.
- alu_b  output  WIDTH  registered, drives ALU inputB.
- alu_op  output  3  registered, drives ALU opcode.
- alu_result  input  WIDTH  from ALU result.
- alu_overflow  input  1  from ALU overflow_flag.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  WIDTH  captured result.
- rsp_overflow  output  1  captured overflow.
- rsp_zero  output  1  1 when rsp_result == 0.
- rsp_illegal  output  1  command carried opcode 110 or 111.
- acc  output  WIDTH  accumulator value.
- op_count  output  16  number of completed response handshakes; wraps from 0xFFFF to 0.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - State goes to IDLE.
  - req_ready=1 (combinational from IDLE); rsp_valid=0.
  - alu_a, alu_b, rsp_result, acc and op_count all 0; alu_op=000; rsp_overflow, rsp_zero and rsp_illegal all 0.
  - Any in-flight command is dropped with no response.
- State machine: IDLE -> WAIT -> RESP -> IDLE.
  - req_ready=1 only in IDLE. rsp_valid=1 only in RESP.
- IDLE, on req_valid & req_ready (accept edge E):
  - alu_a <= req_use_acc ? acc : req_a. This uses the acc value before any same-edge clear.
  - alu_b <= req_b; alu_op <= req_op.
  - Wait counter <= ALU_LATENCY; go to WAIT.
- WAIT:
  - Counter decrements each edge.
  - On the edge where it reaches 0 (edge E+ALU_LATENCY), capture alu_result and alu_overflow into rsp_result and rsp_overflow.
  - On that same edge, set rsp_zero and rsp_illegal (opcode 110/111) and go to RESP.
  - rsp_valid rises in the cycle after edge E+ALU_LATENCY.
- ALU operands stay stable from edge E until the next accept.
- RESP:
  - All rsp_* outputs are held stable while rsp_valid & !rsp_ready.
  - On rsp_valid & rsp_ready: op_count increments and the state returns to IDLE.
  - req_valid is ignored in RESP; no command is accepted on the response-handshake edge.
  - Minimum spacing between accepts is ALU_LATENCY+2 cycles.
- Accumulator:
  - acc <= captured result at the capture edge, only for legal opcodes.
  - For illegal opcodes acc is unchanged; rsp_result still reflects alu_result (0 from the ALU) and rsp_illegal=1.
  - acc_clr forces acc <= 0 on any edge and takes priority over a same-edge capture.
- Arithmetic: no width extension; results and counters wrap modulo 2^WIDTH and 2^16 respectively.

Test Plan:
- Reset then ADD: rst pulse, req_op=000, a=0x0003, b=0x0004, ALU_LATENCY=1 -> rsp_valid 2 cycles after accept; rsp_result=0x0007, rsp_zero=0, rsp_illegal=0, acc=0x0007, op_count=1 after the handshake.
- SUB wrap and zero: SUB 0x0005-0x0007 -> rsp_result=0xFFFE. Then SUB 0x1234-0x1234 -> rsp_result=0x0000, rsp_zero=1.
- Accumulator chain: ADD 0x0010+0x0001 (acc=0x0011), then req_use_acc=1 with XOR b=0x00FF -> alu_a=0x0011, rsp_result=0x00EE. Then acc_clr on the capture edge of a further ADD -> acc=0.
- Backpressure: hold rsp_ready=0 for 5 cycles while req_valid stays high -> rsp_* stable, req_ready=0 throughout, exactly one response; op_count increments once on release.
- Illegal opcode and latency: ALU_LATENCY=3, req_op=110 with acc=0x00AA -> capture at accept+3 edges; rsp_illegal=1, rsp_result=0x0000, acc remains 0x00AA.
- Reset mid-operation: assert rst asynchronously during WAIT -> outputs immediately at reset values, no rsp_valid afterward; the next ADD 0x0001+0x0001 completes normally with 0x0002 and op_count=1.
